// File: rtl/shift_rotate_seq.sv
// shift_rotate_seq: multi-cycle 32-bit shifter/rotator.
// A request is accepted in IDLE and the shift count is consumed one set bit
// per RUN cycle, highest bit first, so the latency equals popcount(amount).
//
// Ports
//   clk      in   rising-edge clock
//   rst_n    in   asynchronous active-low reset
//   start    in   request strobe, sampled only in IDLE
//   op       in   3-bit operation: ROL, ROR, SHL, SHR, SHRA (101-111 illegal)
//   operand  in   32-bit data to shift or rotate
//   amount   in   5-bit shift/rotate count
//   busy     out  high while in RUN
//   done     out  one-cycle completion pulse (high while in DONE)
//   result   out  registered result, loaded on entry to DONE
//   err      out  registered at accept, high for an illegal op
module shift_rotate_seq (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [2:0]  op,
  input  logic [31:0] operand,
  input  logic [4:0]  amount,
  output logic        busy,
  output logic        done,
  output logic [31:0] result,
  output logic        err
);

  localparam int unsigned DataW = 32;
  localparam int unsigned AmtW  = 5;
  localparam int unsigned OpW   = 3;
  localparam int unsigned IdxW  = 3;

  localparam logic [OpW-1:0] OpRol  = 3'b000;
  localparam logic [OpW-1:0] OpRor  = 3'b001;
  localparam logic [OpW-1:0] OpShl  = 3'b010;
  localparam logic [OpW-1:0] OpShr  = 3'b011;
  localparam logic [OpW-1:0] OpShra = 3'b100;

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_RUN  = 2'b01,
    S_DONE = 2'b10
  } state_e;

  state_e             state_q, state_d;
  logic [DataW-1:0]   acc_q, acc_d;
  logic [AmtW-1:0]    rem_q, rem_d;
  logic [OpW-1:0]     op_q, op_d;
  logic [DataW-1:0]   result_q, result_d;
  logic               err_q, err_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;

  logic [IdxW-1:0]    top_idx;
  logic [AmtW-1:0]    step_amt;
  logic [DataW-1:0]   step_val;
  logic               op_illegal;

  // One power-of-two step of the latched operation.
  function automatic logic [DataW-1:0] step_f(input logic [OpW-1:0]   o,
                                              input logic [DataW-1:0] x,
                                              input logic [AmtW-1:0]  s);
    logic [5:0] inv;
    inv = 6'd32 - 6'(s);
    case (o)
      OpRol:   step_f = (x << s) | (x >> inv);
      OpRor:   step_f = (x >> s) | (x << inv);
      OpShl:   step_f = x << s;
      OpShr:   step_f = x >> s;
      OpShra:  step_f = DataW'($signed(x) >>> s);
      default: step_f = x;
    endcase
  endfunction

  assign op_illegal = (op >= 3'b101);

  // Highest set bit of the remaining count; later iterations win.
  always_comb begin
    top_idx = '0;
    for (int unsigned i = 0; i < AmtW; i++) begin
      if (rem_q[i]) top_idx = IdxW'(i);
    end
  end

  assign step_amt = AmtW'(1) << top_idx;
  assign step_val = step_f(op_q, acc_q, step_amt);

  // Next-state and datapath update.
  always_comb begin
    state_d  = state_q;
    acc_d    = acc_q;
    rem_d    = rem_q;
    op_d     = op_q;
    result_d = result_q;
    err_d    = err_q;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          acc_d = operand;
          rem_d = amount;
          op_d  = op;
          err_d = op_illegal;
          if ((amount == '0) || op_illegal) begin
            state_d  = S_DONE;
            result_d = operand;
          end else begin
            state_d = S_RUN;
          end
        end
      end
      S_RUN: begin
        acc_d = step_val;
        rem_d = rem_q & ~step_amt;
        if (rem_d == '0) begin
          state_d  = S_DONE;
          result_d = step_val;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    busy_d = (state_d == S_RUN);
    done_d = (state_d == S_DONE);
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      acc_q    <= '0;
      rem_q    <= '0;
      op_q     <= '0;
      result_q <= '0;
      err_q    <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      acc_q    <= acc_d;
      rem_q    <= rem_d;
      op_q     <= op_d;
      result_q <= result_d;
      err_q    <= err_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  assign busy   = busy_q;
  assign done   = done_q;
  assign result = result_q;
  assign err    = err_q;

endmodule

// File: tb/tb_shift_rotate_seq.sv
// Bench for shift_rotate_seq: a transaction-level model (full shift in one go,
// latency = popcount) checked every cycle, plus directed literal vectors.
module tb_shift_rotate_seq;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [2:0]  op;
  logic [31:0] operand;
  logic [4:0]  amount;
  logic        busy;
  logic        done;
  logic [31:0] result;
  logic        err;

  int n_checks = 0;
  int n_fail   = 0;

  shift_rotate_seq dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (start),
    .op      (op),
    .operand (operand),
    .amount  (amount),
    .busy    (busy),
    .done    (done),
    .result  (result),
    .err     (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Whole-operation reference: the result of shifting by the full amount.
  function automatic logic [31:0] ref_op(input logic [2:0] o, input logic [31:0] x,
                                         input logic [4:0] a);
    logic [63:0] dbl;
    dbl = {x, x};
    case (o)
      3'd0:    begin dbl = dbl << a; ref_op = dbl[63:32]; end
      3'd1:    begin dbl = dbl >> a; ref_op = dbl[31:0];  end
      3'd2:    ref_op = x << a;
      3'd3:    ref_op = x >> a;
      3'd4:    ref_op = 32'($signed(x) >>> a);
      default: ref_op = x;
    endcase
  endfunction

  // Model: phase 0 idle, 1 busy, 2 done; m_cnt counts remaining busy cycles.
  int          m_phase;
  int          m_cnt;
  logic        m_err;
  logic [31:0] m_res;
  logic [31:0] m_pend;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_phase <= 0;
      m_cnt   <= 0;
      m_err   <= 1'b0;
      m_res   <= '0;
      m_pend  <= '0;
    end else begin
      case (m_phase)
        0: if (start) begin : accept
          int lat;
          lat = (op >= 3'd5) ? 0 : $countones(amount);
          m_err  <= (op >= 3'd5);
          m_pend <= ref_op(op, operand, amount);
          if (lat == 0) begin
            m_phase <= 2;
            m_res   <= ref_op(op, operand, amount);
          end else begin
            m_phase <= 1;
            m_cnt   <= lat;
          end
        end
        1: begin
          if (m_cnt == 1) begin
            m_phase <= 2;
            m_res   <= m_pend;
          end
          m_cnt <= m_cnt - 1;
        end
        default: m_phase <= 0;
      endcase
    end
  end

  // Cycle-by-cycle comparison against the model.
  always @(negedge clk) begin
    chk("cyc_busy",   32'(busy),   32'(m_phase == 1));
    chk("cyc_done",   32'(done),   32'(m_phase == 2));
    chk("cyc_err",    32'(err),    32'(m_err));
    chk("cyc_result", result,      m_res);
  end

  // Issue one request and check latency, result and err against literals.
  task automatic run_op(input string name, input logic [2:0] o, input logic [31:0] x,
                        input logic [4:0] a, input logic [31:0] exp_res,
                        input logic exp_err, input int exp_lat);
    int cyc;
    int guard;
    op = o; operand = x; amount = a; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    cyc = 0;
    guard = 0;
    while (!done && guard < 40) begin
      if (busy) cyc++;
      @(negedge clk);
      guard++;
    end
    if (!done) begin
      n_checks++;
      n_fail++;
      $display("FAIL %s_timeout: done not seen within 40 cycles", name);
    end else begin
      chk({name, "_lat"}, 32'(cyc), 32'(exp_lat));
      chk({name, "_res"}, result, exp_res);
      chk({name, "_err"}, 32'(err), 32'(exp_err));
    end
    @(negedge clk);
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; op = '0; operand = '0; amount = '0;
    @(negedge clk);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_res",  result,    32'd0);
    chk("rst_err",  32'(err),  32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    run_op("rol1",   3'd0, 32'h8000_0001, 5'd1,  32'h0000_0003, 1'b0, 1);
    run_op("ror31",  3'd1, 32'h1234_5678, 5'd31, 32'h2468_ACF0, 1'b0, 5);
    run_op("shra4",  3'd4, 32'h8000_0000, 5'd4,  32'hF800_0000, 1'b0, 1);
    run_op("shr4",   3'd3, 32'h8000_0000, 5'd4,  32'h0800_0000, 1'b0, 1);
    run_op("shl0",   3'd2, 32'hDEAD_BEEF, 5'd0,  32'hDEAD_BEEF, 1'b0, 0);
    run_op("ill7",   3'd7, 32'hCAFE_F00D, 5'd7,  32'hCAFE_F00D, 1'b1, 0);
    run_op("rol8",   3'd0, 32'h1234_5678, 5'd8,  32'h3456_7812, 1'b0, 1);
    run_op("shl31",  3'd2, 32'h0000_0001, 5'd31, 32'h8000_0000, 1'b0, 5);
    run_op("shra31", 3'd4, 32'h8000_0000, 5'd31, 32'hFFFF_FFFF, 1'b0, 5);
    run_op("shra31p",3'd4, 32'h7FFF_FFFF, 5'd31, 32'h0000_0000, 1'b0, 5);
    run_op("ror5",   3'd1, 32'h0000_0001, 5'd5,  32'h0800_0000, 1'b0, 2);
    run_op("ill5",   3'd5, 32'h0000_00A5, 5'd3,  32'h0000_00A5, 1'b1, 0);
    run_op("shr13",  3'd3, 32'hF000_000F, 5'd13, 32'h0007_8000, 1'b0, 3);

    // start pulsed mid-RUN with other data must be ignored
    op = 3'd1; operand = 32'h1234_5678; amount = 5'd31; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    op = 3'd2; operand = 32'hFFFF_FFFF; amount = 5'd1; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < 20 && !done; i++) @(negedge clk);
    chk("midrun_done", 32'(done), 32'd1);
    chk("midrun_res",  result, 32'h2468_ACF0);
    @(negedge clk);

    // start held high across DONE is re-accepted after one IDLE cycle
    op = 3'd0; operand = 32'h8000_0001; amount = 5'd1; start = 1'b1;
    @(negedge clk);
    chk("hold_busy1", 32'(busy), 32'd1);
    @(negedge clk);
    chk("hold_done1", 32'(done), 32'd1);
    @(negedge clk);
    chk("hold_idle_busy", 32'(busy), 32'd0);
    chk("hold_idle_done", 32'(done), 32'd0);
    @(negedge clk);
    start = 1'b0;
    chk("hold_busy2", 32'(busy), 32'd1);
    @(negedge clk);
    chk("hold_done2", 32'(done), 32'd1);
    chk("hold_res2",  result, 32'h0000_0003);
    @(negedge clk);

    // reset in the 3rd RUN cycle of SHL 31
    op = 3'd2; operand = 32'h0000_00FF; amount = 5'd31; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("abort_busy_pre", 32'(busy), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_done", 32'(done), 32'd0);
    chk("abort_res",  result,    32'd0);
    chk("abort_err",  32'(err),  32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      chk("abort_nodone", 32'(done), 32'd0);
    end
    run_op("post_rst", 3'd2, 32'h0000_00FF, 5'd31, 32'h8000_0000, 1'b0, 5);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
